// File: rtl/multicycle_control_unit_pkg.sv
// Shared types, encodings and stack defaults for the multi-cycle control unit.
// The op decoder and the ALU-source mapping live here as pure functions.
package multicycle_control_unit_pkg;

  localparam int FUNCT_W     = 7;
  localparam int SP_W        = 16;
  localparam logic [15:0] STACK_TOP = 16'hFFFF;
  localparam int STACK_DEPTH = 64;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_PUSH   = 3'd5,
    ST_POP    = 3'd6,
    ST_TRAP   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    OP_R    = 4'd0,
    OP_ANDI = 4'd1,
    OP_ADDI = 4'd2,
    OP_LW   = 4'd3,
    OP_SW   = 4'd4,
    OP_BEQ  = 4'd5,
    OP_J    = 4'd6,
    OP_JAL  = 4'd7,
    OP_SLL  = 4'd8,
    OP_SLR  = 4'd9,
    OP_SLLV = 4'd10,
    OP_SLRV = 4'd11
  } op_t;

  typedef struct packed {
    logic legal;
    op_t  op;
  } decode_t;

  localparam logic [1:0] TYPE_R = 2'b00;
  localparam logic [1:0] TYPE_I = 2'b01;
  localparam logic [1:0] TYPE_J = 2'b10;
  localparam logic [1:0] TYPE_S = 2'b11;

  localparam logic [1:0] ALU_SRC_REG   = 2'b00;
  localparam logic [1:0] ALU_SRC_SHAMT = 2'b01;
  localparam logic [1:0] ALU_SRC_IMM   = 2'b10;
  localparam logic [1:0] ALU_SRC_VAR   = 2'b11;

  localparam logic [1:0] PC_SRC_NEXT   = 2'b00;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b01;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b10;
  localparam logic [1:0] PC_SRC_RET    = 2'b11;

  localparam logic [1:0] WD_SEL_RT     = 2'b00;
  localparam logic [1:0] WD_SEL_RS     = 2'b01;
  localparam logic [1:0] WD_SEL_RET_PC = 2'b10;

  // sub is the zero-extended low field of funct; anything outside the map is illegal
  function automatic decode_t decode_funct(input logic [1:0] ftype, input logic [31:0] sub);
    decode_t d;
    d.legal = 1'b1;
    d.op    = OP_R;
    case (ftype)
      TYPE_R: d.op = OP_R;
      TYPE_I: begin
        case (sub)
          32'd0:   d.op = OP_ANDI;
          32'd1:   d.op = OP_ADDI;
          32'd2:   d.op = OP_LW;
          32'd3:   d.op = OP_SW;
          32'd4:   d.op = OP_BEQ;
          default: d.legal = 1'b0;
        endcase
      end
      TYPE_J: begin
        case (sub)
          32'd0:   d.op = OP_J;
          32'd1:   d.op = OP_JAL;
          default: d.legal = 1'b0;
        endcase
      end
      TYPE_S: begin
        case (sub)
          32'd0:   d.op = OP_SLL;
          32'd1:   d.op = OP_SLR;
          32'd2:   d.op = OP_SLLV;
          32'd3:   d.op = OP_SLRV;
          default: d.legal = 1'b0;
        endcase
      end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic [1:0] alu_src_of(input op_t op);
    logic [1:0] sel;
    case (op)
      OP_ANDI, OP_ADDI, OP_LW, OP_SW, OP_BEQ: sel = ALU_SRC_IMM;
      OP_SLL, OP_SLR:                         sel = ALU_SRC_SHAMT;
      OP_SLLV, OP_SLRV:                       sel = ALU_SRC_VAR;
      default:                                sel = ALU_SRC_REG;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Shared memory-port handshake between the control unit (master) and the memory/address muxes (slave).
interface multicycle_control_unit_if;
  logic       mem_req;
  logic       mem_read;
  logic       mem_write;
  logic       mem_ready;
  logic [1:0] wd_sel;
  logic       sp_sel;

  modport master (output mem_req, output mem_read, output mem_write,
                  output wd_sel, output sp_sel, input mem_ready);
  modport slave  (input mem_req, input mem_read, input mem_write,
                  input wd_sel, input sp_sel, output mem_ready);
endinterface

// File: rtl/multicycle_control_unit_stack_pointer_unit.sv
// Bounded return-stack pointer: grows down from STACK_TOP, refuses to move past full or empty.
module multicycle_control_unit_stack_pointer_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int              SP_W_P        = SP_W,
  parameter logic [SP_W_P-1:0] STACK_TOP_P = STACK_TOP,
  parameter int              STACK_DEPTH_P = STACK_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_en,
  input  logic              pop_en,
  output logic [SP_W_P-1:0] sp,
  output logic              full,
  output logic              empty
);

  localparam logic [SP_W_P-1:0] FULL_SP = STACK_TOP_P - SP_W_P'(STACK_DEPTH_P);

  logic [SP_W_P-1:0] sp_r;

  // stack pointer register; the bound checks make wrap-around unreachable
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_r <= STACK_TOP_P;
    end else if (push_en && (sp_r != FULL_SP)) begin
      sp_r <= sp_r - SP_W_P'(1);
    end else if (pop_en && (sp_r != STACK_TOP_P)) begin
      sp_r <= sp_r + SP_W_P'(1);
    end else begin
      sp_r <= sp_r;
    end
  end

  assign sp    = sp_r;
  assign full  = (sp_r == FULL_SP);
  assign empty = (sp_r == STACK_TOP_P);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB plus PUSH/POP for the hardware
// return stack and a sticky TRAP state that only reset leaves.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int              FUNCT_W_P     = FUNCT_W,
  parameter int              SP_W_P        = SP_W,
  parameter logic [SP_W_P-1:0] STACK_TOP_P = STACK_TOP,
  parameter int              STACK_DEPTH_P = STACK_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FUNCT_W_P-1:0] funct,
  input  logic                 stop_bit,
  multicycle_control_unit_if.master mem,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 branch,
  output logic                 jump,
  output logic [1:0]           alu_src,
  output logic                 mem_to_reg,
  output logic                 reg_write,
  output logic [SP_W_P-1:0]    sp_out,
  output logic                 busy,
  output logic                 illegal,
  output logic                 stack_ovf,
  output logic                 stack_unf
);

  state_t  state_r, next_s;
  op_t     op_r;
  logic    stop_r;
  logic    illegal_r, ovf_r, unf_r;
  logic    set_illegal_s, set_ovf_s, set_unf_s;
  logic    push_s, pop_s, full_s, empty_s;
  decode_t dec_s;
  state_t  retire_s;

  assign dec_s    = decode_funct(funct[FUNCT_W_P-1 -: 2], 32'(funct[FUNCT_W_P-3:0]));
  // RETIRE is not a state: the last cycle of an instruction jumps straight to POP or FETCH
  assign retire_s = (stop_r && (op_r != OP_JAL)) ? ST_POP : ST_FETCH;

  multicycle_control_unit_stack_pointer_unit #(
    .SP_W_P        (SP_W_P),
    .STACK_TOP_P   (STACK_TOP_P),
    .STACK_DEPTH_P (STACK_DEPTH_P)
  ) u_sp (
    .clk     (clk),
    .rst     (rst),
    .push_en (push_s),
    .pop_en  (pop_s),
    .sp      (sp_out),
    .full    (full_s),
    .empty   (empty_s)
  );

  // state, latched instruction fields and sticky fault flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_FETCH;
      op_r      <= OP_R;
      stop_r    <= 1'b0;
      illegal_r <= 1'b0;
      ovf_r     <= 1'b0;
      unf_r     <= 1'b0;
    end else begin
      state_r   <= next_s;
      if (state_r == ST_DECODE) begin
        op_r   <= dec_s.op;
        stop_r <= stop_bit;
      end
      illegal_r <= illegal_r | set_illegal_s;
      ovf_r     <= ovf_r | set_ovf_s;
      unf_r     <= unf_r | set_unf_s;
    end
  end

  // next-state and control strobes
  always_comb begin
    next_s        = state_r;
    mem.mem_req   = 1'b0;
    mem.mem_read  = 1'b0;
    mem.mem_write = 1'b0;
    mem.wd_sel    = WD_SEL_RT;
    mem.sp_sel    = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = PC_SRC_NEXT;
    branch        = 1'b0;
    jump          = 1'b0;
    alu_src       = ALU_SRC_REG;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    push_s        = 1'b0;
    pop_s         = 1'b0;
    set_illegal_s = 1'b0;
    set_ovf_s     = 1'b0;
    set_unf_s     = 1'b0;
    case (state_r)
      ST_FETCH: begin
        mem.mem_req  = 1'b1;
        mem.mem_read = 1'b1;
        if (mem.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_SRC_NEXT;
          next_s   = ST_DECODE;
        end else begin
          next_s   = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (dec_s.legal) begin
          next_s        = ST_EXEC;
        end else begin
          set_illegal_s = 1'b1;
          next_s        = ST_TRAP;
        end
      end
      ST_EXEC: begin
        alu_src = alu_src_of(op_r);
        case (op_r)
          OP_LW, OP_SW: next_s = ST_MEM;
          OP_BEQ: begin
            branch = 1'b1;
            next_s = retire_s;
          end
          OP_J: begin
            jump     = 1'b1;
            pc_write = 1'b1;
            pc_src   = PC_SRC_JUMP;
            next_s   = retire_s;
          end
          OP_JAL: begin
            if (full_s) begin
              set_ovf_s = 1'b1;
              next_s    = ST_TRAP;
            end else begin
              push_s    = 1'b1;
              next_s    = ST_PUSH;
            end
          end
          default: next_s = ST_WB;
        endcase
      end
      ST_MEM: begin
        mem.mem_req = 1'b1;
        if (op_r == OP_SW) begin
          mem.mem_write = 1'b1;
          mem.wd_sel    = WD_SEL_RT;
        end else begin
          mem.mem_read  = 1'b1;
        end
        if (mem.mem_ready) begin
          next_s = (op_r == OP_SW) ? retire_s : ST_WB;
        end else begin
          next_s = ST_MEM;
        end
      end
      ST_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (op_r == OP_LW) ? 1'b0 : 1'b1;
        next_s     = retire_s;
      end
      ST_PUSH: begin
        mem.mem_req   = 1'b1;
        mem.mem_write = 1'b1;
        mem.sp_sel    = 1'b1;
        mem.wd_sel    = WD_SEL_RET_PC;
        if (mem.mem_ready) begin
          jump     = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_SRC_JUMP;
          next_s   = retire_s;
        end else begin
          next_s   = ST_PUSH;
        end
      end
      ST_POP: begin
        if (empty_s) begin
          set_unf_s = 1'b1;
          next_s    = ST_TRAP;
        end else begin
          mem.mem_req  = 1'b1;
          mem.mem_read = 1'b1;
          mem.sp_sel   = 1'b1;
          if (mem.mem_ready) begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_RET;
            pop_s    = 1'b1;
            next_s   = ST_FETCH;
          end else begin
            next_s   = ST_POP;
          end
        end
      end
      ST_TRAP: next_s = ST_TRAP;
      default: next_s = ST_TRAP;
    endcase
  end

  assign busy      = (state_r != ST_FETCH);
  assign illegal   = illegal_r;
  assign stack_ovf = ovf_r;
  assign stack_unf = unf_r;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: inputs change on the falling edge, outputs are checked 1 ns later.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  funct = 7'd0;
  logic        stop_bit = 1'b0;
  logic        ir_write, pc_write, branch, jump, mem_to_reg, reg_write;
  logic [1:0]  pc_src, alu_src;
  logic [15:0] sp_out;
  logic        busy, illegal, stack_ovf, stack_unf;
  int          errors = 0;
  int          checks = 0;

  multicycle_control_unit_if mem_bus ();

  multicycle_control_unit dut (
    .clk        (clk),
    .rst        (rst),
    .funct      (funct),
    .stop_bit   (stop_bit),
    .mem        (mem_bus.master),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .branch     (branch),
    .jump       (jump),
    .alu_src    (alu_src),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .sp_out     (sp_out),
    .busy       (busy),
    .illegal    (illegal),
    .stack_ovf  (stack_ovf),
    .stack_unf  (stack_unf)
  );

  always #5 clk = ~clk;

  // leaves the bench just after a falling edge with the DUT in FETCH
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mem_bus.mem_ready = 1'b0;
    stop_bit = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0h expected 0", busy); end
    checks++; if (sp_out !== 16'hFFFF) begin errors++; $display("FAIL reset_sp: got %0h expected ffff", sp_out); end
    checks++; if ({illegal, stack_ovf, stack_unf} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %0b expected 000", {illegal, stack_ovf, stack_unf}); end
    checks++; if ({ir_write, pc_write, reg_write, mem_bus.mem_write, mem_bus.sp_sel} !== 5'b00000) begin errors++; $display("FAIL reset_strobes: got %0b expected 00000", {ir_write, pc_write, reg_write, mem_bus.mem_write, mem_bus.sp_sel}); end
    checks++; if ({mem_bus.mem_req, mem_bus.mem_read} !== 2'b11) begin errors++; $display("FAIL reset_fetch_req: got %0b expected 11", {mem_bus.mem_req, mem_bus.mem_read}); end
  endtask

  task automatic test_addi();
    do_reset();
    funct = 7'b0100001; mem_bus.mem_ready = 1'b1;
    #1;
    checks++; if ({ir_write, pc_write, pc_src} !== 4'b1100) begin errors++; $display("FAIL addi_fetch: got %0b expected 1100", {ir_write, pc_write, pc_src}); end
    @(negedge clk); #1;
    checks++; if ({busy, ir_write} !== 2'b10) begin errors++; $display("FAIL addi_decode: got %0b expected 10", {busy, ir_write}); end
    @(negedge clk); #1;
    checks++; if (alu_src !== 2'b10) begin errors++; $display("FAIL addi_alu_src: got %0b expected 10", alu_src); end
    @(negedge clk); #1;
    checks++; if ({reg_write, mem_to_reg} !== 2'b11) begin errors++; $display("FAIL addi_wb: got %0b expected 11", {reg_write, mem_to_reg}); end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL addi_done: got %0h expected 0", busy); end
  endtask

  task automatic test_lw_wait();
    int req_cnt = 0;
    do_reset();
    funct = 7'b0100010; mem_bus.mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    checks++; if (alu_src !== 2'b10) begin errors++; $display("FAIL lw_alu_src: got %0b expected 10", alu_src); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      mem_bus.mem_ready = (k == 3);
      #1;
      if (mem_bus.mem_req) req_cnt++;
      checks++; if ({mem_bus.mem_read, mem_bus.mem_write, mem_bus.sp_sel} !== 3'b100) begin errors++; $display("FAIL lw_mem_dir: got %0b expected 100", {mem_bus.mem_read, mem_bus.mem_write, mem_bus.sp_sel}); end
    end
    checks++; if (req_cnt !== 4) begin errors++; $display("FAIL lw_req_cycles: got %0d expected 4", req_cnt); end
    @(negedge clk); #1;
    checks++; if ({reg_write, mem_to_reg, mem_bus.mem_req} !== 3'b100) begin errors++; $display("FAIL lw_wb: got %0b expected 100", {reg_write, mem_to_reg, mem_bus.mem_req}); end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lw_total8: got busy %0h expected 0", busy); end
  endtask

  task automatic test_sw();
    do_reset();
    funct = 7'b0100011; mem_bus.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if ({mem_bus.mem_write, mem_bus.mem_read, mem_bus.wd_sel, mem_bus.sp_sel} !== 5'b10000) begin errors++; $display("FAIL sw_mem: got %0b expected 10000", {mem_bus.mem_write, mem_bus.mem_read, mem_bus.wd_sel, mem_bus.sp_sel}); end
    @(negedge clk); #1;
    checks++; if ({busy, reg_write} !== 2'b00) begin errors++; $display("FAIL sw_done: got %0b expected 00", {busy, reg_write}); end
  endtask

  task automatic test_branch_jump();
    do_reset();
    funct = 7'b1000000; mem_bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if ({jump, pc_write, pc_src} !== 4'b1101) begin errors++; $display("FAIL j_exec: got %0b expected 1101", {jump, pc_write, pc_src}); end
    @(negedge clk); #1;
    checks++; if ({busy, ir_write} !== 2'b01) begin errors++; $display("FAIL j_3cyc: got %0b expected 01", {busy, ir_write}); end
    do_reset();
    funct = 7'b0100100; mem_bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if ({branch, jump, pc_write, alu_src} !== 5'b10010) begin errors++; $display("FAIL beq_exec: got %0b expected 10010", {branch, jump, pc_write, alu_src}); end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL beq_3cyc: got %0h expected 0", busy); end
    do_reset();
    funct = 7'b1100010; mem_bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (alu_src !== 2'b11) begin errors++; $display("FAIL sllv_alu_src: got %0b expected 11", alu_src); end
    @(negedge clk); #1;
    checks++; if ({reg_write, mem_to_reg} !== 2'b11) begin errors++; $display("FAIL sllv_wb: got %0b expected 11", {reg_write, mem_to_reg}); end
  endtask

  task automatic test_jal_pop();
    do_reset();
    funct = 7'b1000001; mem_bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (sp_out !== 16'hFFFF) begin errors++; $display("FAIL jal_exec_sp: got %0h expected ffff", sp_out); end
    @(negedge clk);
    mem_bus.mem_ready = 1'b0;
    #1;
    checks++; if ({sp_out, mem_bus.mem_write, mem_bus.sp_sel, mem_bus.wd_sel, jump} !== {16'hFFFE, 5'b11100}) begin errors++; $display("FAIL jal_push: got %0h/%0b expected fffe/11100", sp_out, {mem_bus.mem_write, mem_bus.sp_sel, mem_bus.wd_sel, jump}); end
    @(negedge clk);
    mem_bus.mem_ready = 1'b1;
    #1;
    checks++; if ({jump, pc_write, pc_src} !== 4'b1101) begin errors++; $display("FAIL jal_push_done: got %0b expected 1101", {jump, pc_write, pc_src}); end
    @(negedge clk);
    funct = 7'b0000000; stop_bit = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL jal_4cyc: got %0h expected 0", busy); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (reg_write !== 1'b1) begin errors++; $display("FAIL ret_add_wb: got %0h expected 1", reg_write); end
    @(negedge clk); #1;
    checks++; if ({sp_out, mem_bus.mem_read, mem_bus.sp_sel, pc_write, pc_src} !== {16'hFFFE, 5'b11111}) begin errors++; $display("FAIL pop: got %0h/%0b expected fffe/11111", sp_out, {mem_bus.mem_read, mem_bus.sp_sel, pc_write, pc_src}); end
    @(negedge clk); #1;
    checks++; if ({sp_out, busy} !== {16'hFFFF, 1'b0}) begin errors++; $display("FAIL pop_done: got %0h/%0b expected ffff/0", sp_out, busy); end
  endtask

  task automatic test_overflow();
    int wr_cnt = 0;
    do_reset();
    funct = 7'b1000001; stop_bit = 1'b0; mem_bus.mem_ready = 1'b1;
    #1;
    for (int i = 0; i < 280; i++) begin
      if (i == 256) begin
        checks++; if ({sp_out, stack_ovf} !== {16'hFFBF, 1'b0}) begin errors++; $display("FAIL ovf_64_pushed: got %0h/%0b expected ffbf/0", sp_out, stack_ovf); end
      end
      if (mem_bus.mem_write) wr_cnt++;
      @(negedge clk); #1;
    end
    checks++; if (wr_cnt !== 64) begin errors++; $display("FAIL ovf_push_count: got %0d expected 64", wr_cnt); end
    checks++; if ({stack_ovf, busy, mem_bus.mem_req, ir_write} !== 4'b1100) begin errors++; $display("FAIL ovf_trap: got %0b expected 1100", {stack_ovf, busy, mem_bus.mem_req, ir_write}); end
    checks++; if (sp_out !== 16'hFFBF) begin errors++; $display("FAIL ovf_sp: got %0h expected ffbf", sp_out); end
  endtask

  task automatic test_underflow_illegal();
    do_reset();
    funct = 7'b0000000; stop_bit = 1'b1; mem_bus.mem_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    checks++; if ({mem_bus.mem_req, pc_write} !== 2'b00) begin errors++; $display("FAIL unf_no_read: got %0b expected 00", {mem_bus.mem_req, pc_write}); end
    repeat (2) @(negedge clk);
    #1;
    checks++; if ({stack_unf, busy, mem_bus.mem_req, ir_write, illegal} !== 5'b11000) begin errors++; $display("FAIL unf_trap: got %0b expected 11000", {stack_unf, busy, mem_bus.mem_req, ir_write, illegal}); end
    do_reset();
    funct = 7'b1011111; stop_bit = 1'b0; mem_bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if ({illegal, busy, mem_bus.mem_req, stack_unf} !== 4'b1100) begin errors++; $display("FAIL illegal_j: got %0b expected 1100", {illegal, busy, mem_bus.mem_req, stack_unf}); end
    do_reset();
    funct = 7'b0100101; mem_bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if ({illegal, busy} !== 2'b11) begin errors++; $display("FAIL illegal_i5: got %0b expected 11", {illegal, busy}); end
  endtask

  task automatic test_rst_mid_push();
    do_reset();
    funct = 7'b1000001; stop_bit = 1'b0; mem_bus.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_bus.mem_ready = 1'b0;
    #1;
    checks++; if ({mem_bus.mem_write, sp_out} !== {1'b1, 16'hFFFE}) begin errors++; $display("FAIL rst_push_active: got %0b/%0h expected 1/fffe", mem_bus.mem_write, sp_out); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if ({busy, sp_out} !== {1'b0, 16'hFFFF}) begin errors++; $display("FAIL rst_push_state: got %0b/%0h expected 0/ffff", busy, sp_out); end
    checks++; if ({mem_bus.mem_write, mem_bus.sp_sel, mem_bus.wd_sel, jump, pc_write, illegal, stack_ovf, stack_unf} !== 9'b0) begin errors++; $display("FAIL rst_push_strobes: got %0b expected 0", {mem_bus.mem_write, mem_bus.sp_sel, mem_bus.wd_sel, jump, pc_write, illegal, stack_ovf, stack_unf}); end
  endtask

  initial begin
    mem_bus.mem_ready = 1'b0;
    test_reset();
    test_addi();
    test_lw_wait();
    test_sw();
    test_branch_jump();
    test_jal_pop();
    test_overflow();
    test_underflow_illegal();
    test_rst_mid_push();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
